// File: rtl/sweep_if.sv
// Control and result bundle between a sweep sequencer and whoever drives it.
// The master starts and aborts sweeps; the slave reports status and results.
interface sweep_if;
    logic        start;
    logic        abort;
    logic        gray_mode;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  ones_cnt;
    logic [3:0]  toggle_cnt;

    modport master (
        output start, abort, gray_mode,
        input  busy, done, truth_table, ones_cnt, toggle_cnt
    );

    modport slave (
        input  start, abort, gray_mode,
        output busy, done, truth_table, ones_cnt, toggle_cnt
    );
endinterface

// File: rtl/subckt_sweep_ctrl.sv
// Walks all 16 input patterns of a 4-input sub-circuit in binary or Gray order,
// waits SETTLE cycles per pattern, then captures the truth table and statistics.
module subckt_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    sweep_if.slave      ctrl,
    output logic [3:0]  vec_out,
    input  logic        res_in
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg;
    logic [3:0]  settle_reg;
    logic        gray_reg;
    logic        prev_reg;
    logic [3:0]  vec_reg;
    logic [15:0] tt_reg;
    logic [4:0]  ones_reg;
    logic [3:0]  tog_reg;

    logic        load_start;
    logic        do_sample;
    logic        do_advance;
    logic        do_abort;
    logic [3:0]  idx_inc;
    logic [3:0]  vec_next;

    assign idx_inc  = idx_reg + 4'd1;
    assign vec_next = gray_reg ? (idx_inc ^ (idx_inc >> 1)) : idx_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Abort wins over everything except reset; start is only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        load_start = 1'b0;
        do_sample  = 1'b0;
        do_advance = 1'b0;
        do_abort   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ctrl.start && !ctrl.abort) begin
                    load_start = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (ctrl.abort) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end else if (settle_reg == 4'd1) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (ctrl.abort) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end else begin
                    do_sample = 1'b1;
                    if (idx_reg == 4'd15) begin
                        state_next = DONE;
                    end else begin
                        do_advance = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg    <= 4'd0;
            settle_reg <= 4'd0;
            gray_reg   <= 1'b0;
            prev_reg   <= 1'b0;
            vec_reg    <= 4'd0;
            ones_reg   <= 5'd0;
            tog_reg    <= 4'd0;
        end else begin
            if (load_start) begin
                gray_reg   <= ctrl.gray_mode;
                idx_reg    <= 4'd0;
                vec_reg    <= 4'd0;
                settle_reg <= SETTLE_INIT;
                ones_reg   <= 5'd0;
                tog_reg    <= 4'd0;
                prev_reg   <= 1'b0;
            end
            if (state_reg == WAIT) begin
                settle_reg <= settle_reg - 4'd1;
            end
            if (do_abort) begin
                vec_reg <= 4'd0;
            end
            if (do_sample) begin
                ones_reg <= ones_reg + {4'd0, res_in};
                prev_reg <= res_in;
                if (idx_reg != 4'd0 && res_in != prev_reg) begin
                    tog_reg <= tog_reg + 4'd1;
                end
            end
            if (do_advance) begin
                idx_reg    <= idx_inc;
                vec_reg    <= vec_next;
                settle_reg <= SETTLE_INIT;
            end
        end
    end

    // Each table bit is indexed by the pattern value, so order does not matter.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_tt
            always_ff @(posedge clk) begin
                if (rst || load_start) begin
                    tt_reg[gi] <= 1'b0;
                end else if (do_sample && vec_reg == 4'(gi)) begin
                    tt_reg[gi] <= res_in;
                end
            end
        end
    endgenerate

    assign vec_out          = vec_reg;
    assign ctrl.busy        = (state_reg == WAIT) || (state_reg == SAMPLE);
    assign ctrl.done        = (state_reg == DONE);
    assign ctrl.truth_table = tt_reg;
    assign ctrl.ones_cnt    = ones_reg;
    assign ctrl.toggle_cnt  = tog_reg;

endmodule

// File: tb/tb_subckt_sweep_ctrl.sv
// Scoreboard bench: expected sweep results are queued when a sweep is started
// and compared when the controller pulses done.
module tb_subckt_sweep_ctrl;

    typedef struct packed {
        logic [15:0] tt;
        logic [4:0]  ones;
        logic [3:0]  tog;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sweep_if sw1 ();
    sweep_if sw3 ();

    logic [3:0] vec1;
    logic [3:0] vec3;
    logic       res1;

    int   n_vec = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    res_t exp3_q[$];
    logic [3:0] vec_q[$];
    res_t mon_e;
    res_t mon3_e;

    // f = n2 XNOR n10, n10 = ~n1 & ~(~n2 & (n3 ^ n4)); bit0..bit3 = n1..n4
    function automatic logic f_model(input logic [3:0] v);
        logic n10;
        n10 = ~v[0] & ~(~v[1] & (v[2] ^ v[3]));
        return ~(v[1] ^ n10);
    endfunction

    assign res1 = f_model(vec1);

    subckt_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (sw1.slave),
        .vec_out (vec1),
        .res_in  (res1)
    );

    subckt_sweep_ctrl #(.SETTLE(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (sw3.slave),
        .vec_out (vec3),
        .res_in  (1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [3:0] order_vec(input logic gray, input int i);
        logic [3:0] b;
        b = 4'(i);
        return gray ? (b ^ (b >> 1)) : b;
    endfunction

    function automatic res_t model_sweep(input logic gray, input bit tied_one);
        res_t r;
        logic v, prev;
        logic [3:0] p;
        r = '0;
        prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            p = order_vec(gray, i);
            v = tied_one ? 1'b1 : f_model(p);
            r.tt[p] = v;
            r.ones  = r.ones + 5'(v);
            if (i > 0 && v != prev) r.tog = r.tog + 4'd1;
            prev = v;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && sw1.done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(sw1.done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("truth_table", 32'(sw1.truth_table), 32'(mon_e.tt));
                chk("ones_cnt", 32'(sw1.ones_cnt), 32'(mon_e.ones));
                chk("toggle_cnt", 32'(sw1.toggle_cnt), 32'(mon_e.tog));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sw3.done) begin
            if (exp3_q.size() == 0) begin
                chk("spurious_done3", 32'(sw3.done), 32'd0);
            end else begin
                mon3_e = exp3_q.pop_front();
                chk("truth_table3", 32'(sw3.truth_table), 32'(mon3_e.tt));
                chk("ones_cnt3", 32'(sw3.ones_cnt), 32'(mon3_e.ones));
                chk("toggle_cnt3", 32'(sw3.toggle_cnt), 32'(mon3_e.tog));
            end
        end
    end

    task automatic run_sweep(input logic gray);
        res_t       e;
        logic [3:0] last;
        bit         first;
        int         lat;
        e = model_sweep(gray, 1'b0);
        @(negedge clk);
        sw1.gray_mode = gray;
        sw1.start     = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) vec_q.push_back(order_vec(gray, i));
        @(negedge clk);
        sw1.start     = 1'b0;
        sw1.gray_mode = ~gray;
        first = 1'b1;
        last  = 4'd0;
        lat   = 0;
        for (int k = 1; k <= 200; k++) begin
            if (sw1.busy && (first || vec1 != last)) begin
                if (vec_q.size() > 0) chk("vec_order", 32'(vec1), 32'(vec_q.pop_front()));
                else chk("vec_extra", 32'(vec1), 32'hFFFF_FFFF);
                last  = vec1;
                first = 1'b0;
            end
            if (sw1.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("done_cycle", 32'(lat), 32'd33);
        chk("vec_left", 32'(vec_q.size()), 32'd0);
        vec_q.delete();
        @(negedge clk);
        chk("done_width", 32'(sw1.done), 32'd0);
        repeat (3) @(negedge clk);
        chk("tt_hold", 32'(sw1.truth_table), 32'(e.tt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int lat3;
        sw1.start = 1'b0; sw1.abort = 1'b0; sw1.gray_mode = 1'b0;
        sw3.start = 1'b0; sw3.abort = 1'b0; sw3.gray_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(sw1.busy), 32'd0);
        chk("rst_vec", 32'(vec1), 32'd0);
        chk("rst_tt", 32'(sw1.truth_table), 32'd0);
        chk("rst_ones", 32'(sw1.ones_cnt), 32'd0);
        rst = 1'b0;

        run_sweep(1'b0);
        run_sweep(1'b1);

        // abort beats start in IDLE
        @(negedge clk);
        sw1.start = 1'b1; sw1.abort = 1'b1;
        @(negedge clk);
        sw1.start = 1'b0; sw1.abort = 1'b0;
        chk("abort_over_start", 32'(sw1.busy), 32'd0);

        // abort mid-sweep at idx 5
        sw1.gray_mode = 1'b0; sw1.start = 1'b1;
        @(negedge clk);
        sw1.start = 1'b0;
        for (int k = 0; k < 100 && vec1 != 4'd5; k++) @(negedge clk);
        chk("reach_idx5", 32'(vec1), 32'd5);
        sw1.abort = 1'b1;
        @(negedge clk);
        sw1.abort = 1'b0;
        chk("abort_busy", 32'(sw1.busy), 32'd0);
        chk("abort_vec", 32'(vec1), 32'd0);
        chk("abort_done", 32'(sw1.done), 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_idle", 32'(sw1.busy), 32'd0);
        run_sweep(1'b0);

        // reset in SAMPLE at idx 9 with start held high all along
        sw1.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 100 && vec1 != 4'd9; k++) @(negedge clk);
        chk("held_start_reach9", 32'(vec1), 32'd9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst9_busy", 32'(sw1.busy), 32'd0);
        chk("rst9_vec", 32'(vec1), 32'd0);
        chk("rst9_tt", 32'(sw1.truth_table), 32'd0);
        chk("rst9_ones", 32'(sw1.ones_cnt), 32'd0);
        chk("rst9_tog", 32'(sw1.toggle_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("start_after_rst", 32'(sw1.busy), 32'd1);
        sw1.start = 1'b0;
        sw1.abort = 1'b1;
        @(negedge clk);
        sw1.abort = 1'b0;
        chk("abort_after_rst", 32'(sw1.busy), 32'd0);

        // SETTLE=3 instance with res_in tied high
        exp3_q.push_back(model_sweep(1'b0, 1'b1));
        sw3.start = 1'b1;
        @(negedge clk);
        sw3.start = 1'b0;
        lat3 = 0;
        for (int k = 1; k <= 300; k++) begin
            if (sw3.done) begin
                lat3 = k;
                break;
            end
            @(negedge clk);
        end
        chk("done_cycle3", 32'(lat3), 32'd65);
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size() + exp3_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
